// File: rtl/timer_pkg.sv
// Shared definitions for the countdown clock: state encoding, BCD digit sizing,
// per-digit maxima and the bit positions of each digit in the packed value.
package timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_MIN  = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_TENS = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_ONES = 4'd9;

  localparam int ONES_LSB = 0;
  localparam int TENS_LSB = 4;
  localparam int MIN_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Out-of-range BCD entries from the front panel saturate at the digit maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clear, parallel load and a borrow out that
// fires when a decrement wraps the digit from 0 back to MAX.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] value,
  output logic               borrow
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (ld) begin
      value <= ld_val;
    end else if (dec) begin
      value <= (value == '0) ? MAX : value - 1'b1;
    end
  end

  assign borrow = dec && (value == '0);

endmodule

// File: rtl/countdown_controller.sv
// Countdown clock sequencer: 1-second prescaler, M:ST:SO BCD down-count chain
// and the IDLE/RUN/PAUSE/DONE state machine driving the display and expiry pulse.
module countdown_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [11:0] load_value,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [11:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic [1:0]  state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        cur;
  logic [PW-1:0] presc;

  logic [DIGIT_W-1:0] ones_val, tens_val, min_val;
  logic               ones_borrow, tens_borrow, min_borrow;
  logic               load_ok, tick, final_tick, is_zero, go;

  assign digits  = {min_val, tens_val, ones_val};
  assign state   = cur;
  assign is_zero = (digits == 12'h000);
  assign go      = start && !pause;

  assign load_ok = load && !clear && (cur == IDLE || cur == DONE);
  assign tick    = (cur == RUN) && !clear && !pause && (presc == PRESC_LAST);
  // min_borrow can only fire if RUN were ever reached at 0:00; treat it as expiry too.
  assign final_tick = tick && ((digits == 12'h001) || min_borrow);

  bcd_down_digit #(.MAX(MAX_ONES)) u_ones (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .ld     (load_ok),
    .ld_val (clamp_digit(load_value[ONES_LSB +: DIGIT_W], MAX_ONES)),
    .dec    (tick),
    .value  (ones_val),
    .borrow (ones_borrow)
  );

  bcd_down_digit #(.MAX(MAX_TENS)) u_tens (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .ld     (load_ok),
    .ld_val (clamp_digit(load_value[TENS_LSB +: DIGIT_W], MAX_TENS)),
    .dec    (ones_borrow),
    .value  (tens_val),
    .borrow (tens_borrow)
  );

  bcd_down_digit #(.MAX(MAX_MIN)) u_min (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .ld     (load_ok),
    .ld_val (clamp_digit(load_value[MIN_LSB +: DIGIT_W], MAX_MIN)),
    .dec    (tens_borrow),
    .value  (min_val),
    .borrow (min_borrow)
  );

  // Commands resolve clear > load > pause > start; expired only fires on entry to DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur     <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        cur     <= IDLE;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (load_ok) begin
        cur     <= IDLE;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (cur)
          IDLE, DONE: begin
            if (go) begin
              if (is_zero) begin
                cur     <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
                expired <= (cur == IDLE);
              end else begin
                cur     <= RUN;
                presc   <= '0;
                running <= 1'b1;
                done    <= 1'b0;
              end
            end
          end
          RUN: begin
            if (pause) begin
              cur     <= PAUSE;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (final_tick) begin
                cur     <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
                expired <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (go) begin
              cur     <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            cur     <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/countdown_controller.md
# countdown_controller

Sequencer for the game's countdown clock. Owns a cascaded BCD down-count chain (M:ST:SO, 9:59 max), a 1-second prescaler and a start/pause/done state machine. Converts front-panel style commands (load, start, pause, clear) into digit enables and borrows. Raises a one-cycle `expired` pulse when the count reaches 0:00. Sits between the input debouncers and the seven-segment display drivers.

## Interface
- `TICK_DIV`, default 50_000_000: number of `clk` cycles per count-down tick. Minimum 2.
- `clk`  input  1  system clock; all state changes on its posedge.
- `resetn`  input  1  one clock; reset is synchronous and active-low.
- `load`  input  1  capture `load_value` into the digits (honoured in IDLE and DONE only).
- `load_value`  input  12  BCD {minutes[11:8], sec_tens[7:4], sec_ones[3:0]}.
- `start`  input  1  begin or resume counting.
- `pause`  input  1  suspend counting.
- `clear`  input  1  abort to IDLE and zero the digits (any state).
- `digits`  output  12  current BCD value, same packing as `load_value`.
- `running`  output  1  high exactly while in RUN.
- `done`  output  1  high exactly while in DONE.
- `expired`  output  1  one-cycle pulse on entry to DONE.
- `state`  output  2  current FSM state encoding (debug / LEDs).

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Reset (`resetn`=0 at a posedge): IDLE; `digits`=0x000; prescaler=0; `running`=`done`=`expired`=0.
- Command priority, evaluated each cycle: `clear` > `load` > `pause` > `start`.
- `clear`: next state IDLE, `digits`=0x000, prescaler=0. Allowed from any state.
- `load` in IDLE/DONE: capture `load_value` with clamping: minutes>9 becomes 9; sec_tens>5 becomes 5; sec_ones>9 becomes 9. Next state IDLE. Ignored in RUN and PAUSE.
- IDLE + `start`:
  - nonzero digits: go to RUN, prescaler=0.
  - digits 0x000: go to DONE, with `expired` pulsed.
- RUN:
  - `pause`: go to PAUSE, prescaler held.
  - Otherwise prescaler increments. At `TICK_DIV-1` it wraps to 0 and the chain decrements by one second.
- Decrement: sec_ones 9..0 then wraps to 9 with a borrow. sec_tens 5..0 then wraps to 5 with a borrow. Minutes decrement on that borrow.
- Decrement landing on 0x000: same edge transitions to DONE. `expired`=1 for the following cycle only.
- PAUSE + `start`: back to RUN; prescaler resumes from its held value (no restart of the partial second).
- DONE: digits hold 0x000 until `load` or `clear`. `start` in DONE acts as in IDLE with the current digits.
- `start` and `pause` simultaneous in RUN: pause wins. Simultaneous in PAUSE: stay in PAUSE.

## Timing
- All outputs registered; commands sampled at posedge N take effect in outputs after posedge N.
- Latency from entering RUN to first decrement: exactly `TICK_DIV` cycles. Subsequent decrements every `TICK_DIV` cycles while in RUN.
- Total RUN cycles from value V seconds to DONE: V×`TICK_DIV`, excluding PAUSE time.
- `expired` never asserts twice without an intervening exit from DONE.
- Reset mid-RUN overrides everything on that edge, including a coincident tick.
- A `clear` on the same edge as the final tick yields IDLE/0x000 with no `expired`.

## Structure
- Shared package `timer_pkg`:
  - state encoding constants;
  - BCD digit width (4);
  - digit maxima (9, 5, 9);
  - packed-field bit positions.
- Sub-module `bcd_down_digit`, instantiated three times. Parameter `MAX`. Inputs: `clk`, `resetn`, `clr`, `ld`, `ld_val`, `dec`. Outputs: `value`, `borrow`. `borrow` is combinational: `dec` && value==0.
- Controller owns the FSM, the prescaler (width $clog2(TICK_DIV)), load clamping and the zero-detect.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset: assert `resetn`=0 for 2 cycles mid-RUN -> `digits`=0x000, `state`=0, all flags 0.
- Count-down cascade: load 0x105, start.
  - `digits`=0x104 exactly 4 cycles after RUN entry.
  - 0x059 after 6 ticks (24 cycles).
  - DONE after 260 cycles.
  - `expired` high for exactly 1 cycle.
- Pause/resume: load 0x002, start, pause on cycle 2 of RUN, hold 10 cycles, start -> first decrement 2 RUN cycles after resume; DONE at 8 total RUN cycles.
- Clamping: load 0xFAB -> `digits`=0x959. Load ignored while RUN (value unchanged).
- Zero start: load 0x000, start -> DONE next cycle, `expired` single pulse.
- Priority corners:
  - `start`+`pause` in RUN -> PAUSE.
  - `clear` coincident with final tick -> IDLE, 0x000, no `expired`.
  - `load`+`start` in IDLE -> value loaded, stays IDLE.
